// File: rtl/vga_sprite_module_pkg.sv
// ---------------------------------------------------------------------------
// vga_sprite_module_pkg
// Shared constants and helpers for the sprite pixel generator.
//   COORD_W : width of the screen column/row coordinates from the sync generator
//   DIFF_W  : width of the signed column/row offsets (one extra bit for sign)
//   clog2() : elaboration-time ceiling log2, used for address/index widths
// ---------------------------------------------------------------------------
package vga_sprite_module_pkg;

    localparam int COORD_W = 11;
    localparam int DIFF_W  = COORD_W + 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/vga_sprite_module_pipe_delay.sv
// ---------------------------------------------------------------------------
// vga_pipe_delay
// Fixed-depth register delay line. DEPTH = 0 degenerates to a plain wire.
//   CLK  : pixel clock
//   RSTn : asynchronous active-low reset, clears every stage to 0
//   din  : WIDTH-bit input word
//   dout : din delayed by DEPTH clock cycles
// ---------------------------------------------------------------------------
module vga_pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_regs
            logic [WIDTH-1:0] stage [DEPTH];

            // NOTE: the stages carry Ready_Sig, so they are reset like ordinary
            // flops; this keeps the first cycles after reset at a known 0.
            always_ff @(posedge CLK or negedge RSTn) begin
                if (!RSTn) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= '0;
                    end
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_sprite_module.sv
// ---------------------------------------------------------------------------
// vga_sprite_module
// Draws a 1-bpp ROM bitmap as a sprite at a programmable screen position,
// with optional 2x scaling, fg/bg colours and frame-synchronous blinking.
// Output latency L = ROM_LAT + 2 cycles.
//   CLK, RSTn             : pixel clock, asynchronous active-low reset
//   Ready_Sig             : active-video qualifier from the sync generator
//   Column_Addr_Sig       : current pixel column
//   Row_Addr_Sig          : current pixel row
//   Frame_Sig             : one-cycle pulse per frame (vertical blanking)
//   Pos_X, Pos_Y, Scale2x,
//   Blink_En, Fg_Color,
//   Bg_Color              : sprite controls, captured only on Frame_Sig
//   Rom_Data / Rom_Addr   : bitmap ROM row (column 0 = MSB) / row index
//   Red/Green/Blue_Sig    : colour channels to the DAC
//   Pix_Valid             : Ready_Sig delayed by L
// ---------------------------------------------------------------------------
module vga_sprite_module
    import vga_sprite_module_pkg::*;
#(
    parameter int IMG_W        = 64,
    parameter int IMG_H        = 64,
    parameter int COLOR_W      = 1,
    parameter int ROM_LAT      = 0,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    input  logic                    Ready_Sig,
    input  logic [COORD_W-1:0]      Column_Addr_Sig,
    input  logic [COORD_W-1:0]      Row_Addr_Sig,
    input  logic                    Frame_Sig,
    input  logic [COORD_W-1:0]      Pos_X,
    input  logic [COORD_W-1:0]      Pos_Y,
    input  logic                    Scale2x,
    input  logic                    Blink_En,
    input  logic [3*COLOR_W-1:0]    Fg_Color,
    input  logic [3*COLOR_W-1:0]    Bg_Color,
    input  logic [IMG_W-1:0]        Rom_Data,
    output logic [clog2(IMG_H)-1:0] Rom_Addr,
    output logic [COLOR_W-1:0]      Red_Sig,
    output logic [COLOR_W-1:0]      Green_Sig,
    output logic [COLOR_W-1:0]      Blue_Sig,
    output logic                    Pix_Valid
);

    localparam int AW = clog2(IMG_H);
    localparam int IW = clog2(IMG_W);
    localparam int CW = 3 * COLOR_W;
    localparam int PW = 2 + IW + 2 * CW;

    // ------------------------------------------------------------------
    // Shadow registers: mid-frame input changes stay invisible until the
    // next Frame_Sig.
    // ------------------------------------------------------------------
    logic [COORD_W-1:0] pos_x_q, pos_y_q;
    logic               scale_q, blink_en_q;
    logic [CW-1:0]      fg_q, bg_q;

    // NOTE: asynchronous active-low reset -- RSTn sits in the sensitivity
    // list so outputs clear without waiting for a clock edge.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            scale_q    <= 1'b0;
            blink_en_q <= 1'b0;
            fg_q       <= '1;
            bg_q       <= '0;
        end else if (Frame_Sig) begin
            pos_x_q    <= Pos_X;
            pos_y_q    <= Pos_Y;
            scale_q    <= Scale2x;
            blink_en_q <= Blink_En;
            fg_q       <= Fg_Color;
            bg_q       <= Bg_Color;
        end
    end

    // ------------------------------------------------------------------
    // Blink: frame counter wraps at BLINK_FRAMES-1 and toggles visibility.
    // Disabled blink holds the counter at 0 and the sprite visible, so a
    // later enable starts a fresh half-period.
    // ------------------------------------------------------------------
    logic [7:0] frame_cnt_q;
    logic       visible_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            frame_cnt_q <= '0;
            visible_q   <= 1'b1;
        end else if (!blink_en_q) begin
            frame_cnt_q <= '0;
            visible_q   <= 1'b1;
        end else if (Frame_Sig) begin
            if (frame_cnt_q == 8'(BLINK_FRAMES - 1)) begin
                frame_cnt_q <= '0;
                visible_q   <= ~visible_q;
            end else begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Extent compare and ROM addressing. Offsets are one bit wider than the
    // coordinates so a pixel left of / above the sprite shows up as a set
    // sign bit instead of wrapping into range.
    // ------------------------------------------------------------------
    logic [DIFF_W-1:0] dx, dy, extent_w, extent_h;
    logic              inside_x, inside_y, hit_en;
    logic [IW-1:0]     bit_idx;
    logic [AW-1:0]     rom_addr_d;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        dx         = {1'b0, Column_Addr_Sig} - {1'b0, pos_x_q};
        dy         = {1'b0, Row_Addr_Sig} - {1'b0, pos_y_q};
        extent_w   = scale_q ? DIFF_W'(2 * IMG_W) : DIFF_W'(IMG_W);
        extent_h   = scale_q ? DIFF_W'(2 * IMG_H) : DIFF_W'(IMG_H);
        inside_x   = !dx[DIFF_W-1] && (dx < extent_w);
        inside_y   = !dy[DIFF_W-1] && (dy < extent_h);
        hit_en     = inside_x && inside_y && visible_q;
        bit_idx    = IW'(DIFF_W'(IMG_W - 1) - (scale_q ? (dx >> 1) : dx));
        rom_addr_d = '0;
        if (inside_y) begin
            rom_addr_d = AW'(scale_q ? (dy >> 1) : dy);
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            Rom_Addr <= '0;
        end else begin
            Rom_Addr <= rom_addr_d;
        end
    end

    // ------------------------------------------------------------------
    // Side-band pipeline: everything the output stage needs travels beside
    // the ROM access, including the colours, so a pixel is always drawn with
    // the shadow values that were live when its address was issued.
    // ------------------------------------------------------------------
    logic [PW-1:0] side_in, side_out;
    logic          ready_d, hit_d;
    logic [IW-1:0] idx_d;
    logic [CW-1:0] fg_d, bg_d;

    assign side_in = {Ready_Sig, hit_en, bit_idx, fg_q, bg_q};

    vga_pipe_delay #(
        .WIDTH (PW),
        .DEPTH (ROM_LAT + 1)
    ) u_side_delay (
        .CLK  (CLK),
        .RSTn (RSTn),
        .din  (side_in),
        .dout (side_out)
    );

    assign {ready_d, hit_d, idx_d, fg_d, bg_d} = side_out;

    // ------------------------------------------------------------------
    // Output register: colour select.
    // ------------------------------------------------------------------
    logic [CW-1:0] rgb_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rgb_q     <= '0;
            Pix_Valid <= 1'b0;
        end else begin
            Pix_Valid <= ready_d;
            if (!ready_d) begin
                rgb_q <= '0;
            end else if (hit_d && Rom_Data[idx_d]) begin
                rgb_q <= fg_d;
            end else begin
                rgb_q <= bg_d;
            end
        end
    end

    assign Red_Sig   = rgb_q[CW-1 -: COLOR_W];
    assign Green_Sig = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign Blue_Sig  = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_sprite_module.sv
// ---------------------------------------------------------------------------
// tb_vga_sprite_module
// Directed bench for vga_sprite_module. Two instances share all inputs:
// u_a (ROM_LAT = 0, L = 2) and u_b (ROM_LAT = 2, L = 4), both with
// BLINK_FRAMES = 3. Bitmap row r is 64'h8000_1000_0000_0001 with r placed
// in bits 13:8, i.e. bitmap columns 0, 19 and 63 are set on every row.
// ---------------------------------------------------------------------------
module tb_vga_sprite_module;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ready, frame;
    logic [10:0] col, row, pos_x, pos_y;
    logic        scale, blink;
    logic [2:0]  fg, bg;

    logic [63:0] rom_data_a, rom_data_b, rom_b_q1, rom_b_q2;
    logic [5:0]  rom_addr_a, rom_addr_b;
    logic        red_a, green_a, blue_a, valid_a;
    logic        red_b, green_b, blue_b, valid_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [63:0] rom_row(input logic [5:0] r);
        return 64'h8000_1000_0000_0001 | ({58'd0, r} << 8);
    endfunction

    assign rom_data_a = rom_row(rom_addr_a);

    always @(posedge clk) begin
        rom_b_q1 <= rom_row(rom_addr_b);
        rom_b_q2 <= rom_b_q1;
    end
    assign rom_data_b = rom_b_q2;

    vga_sprite_module #(.ROM_LAT(0), .BLINK_FRAMES(3)) u_a (
        .CLK(clk), .RSTn(rstn), .Ready_Sig(ready),
        .Column_Addr_Sig(col), .Row_Addr_Sig(row), .Frame_Sig(frame),
        .Pos_X(pos_x), .Pos_Y(pos_y), .Scale2x(scale), .Blink_En(blink),
        .Fg_Color(fg), .Bg_Color(bg), .Rom_Data(rom_data_a),
        .Rom_Addr(rom_addr_a), .Red_Sig(red_a), .Green_Sig(green_a),
        .Blue_Sig(blue_a), .Pix_Valid(valid_a)
    );

    vga_sprite_module #(.ROM_LAT(2), .BLINK_FRAMES(3)) u_b (
        .CLK(clk), .RSTn(rstn), .Ready_Sig(ready),
        .Column_Addr_Sig(col), .Row_Addr_Sig(row), .Frame_Sig(frame),
        .Pos_X(pos_x), .Pos_Y(pos_y), .Scale2x(scale), .Blink_En(blink),
        .Fg_Color(fg), .Bg_Color(bg), .Rom_Data(rom_data_b),
        .Rom_Addr(rom_addr_b), .Red_Sig(red_b), .Green_Sig(green_b),
        .Blue_Sig(blue_b), .Pix_Valid(valid_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One Frame_Sig pulse during blanking; shadows load on the enclosed edge.
    task automatic frame_pulse();
        @(negedge clk);
        ready = 1'b0;
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
    endtask

    // Hold one pixel long enough for both pipelines to settle, then compare.
    // exp_addr < 0 skips the Rom_Addr comparison.
    task automatic probe(input int c, input int r, input logic [2:0] exp_rgb, input int exp_addr);
        @(negedge clk);
        col   = 11'(c);
        row   = 11'(r);
        ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check($sformatf("rgb_a(%0d,%0d)", c, r), {29'd0, red_a, green_a, blue_a}, {29'd0, exp_rgb});
        check($sformatf("rgb_b(%0d,%0d)", c, r), {29'd0, red_b, green_b, blue_b}, {29'd0, exp_rgb});
        check($sformatf("valid_a(%0d,%0d)", c, r), {31'd0, valid_a}, 32'd1);
        if (exp_addr >= 0) begin
            check($sformatf("addr_a(%0d,%0d)", c, r), {26'd0, rom_addr_a}, 32'(exp_addr));
        end
    endtask

    initial begin
        rstn  = 1'b0;
        ready = 1'b0;
        frame = 1'b0;
        col   = '0;
        row   = '0;
        pos_x = '0;
        pos_y = '0;
        scale = 1'b0;
        blink = 1'b0;
        fg    = 3'b111;
        bg    = 3'b000;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_rgb_a", {29'd0, red_a, green_a, blue_a}, 32'd0);
        check("reset_valid_a", {31'd0, valid_a}, 32'd0);
        check("reset_valid_b", {31'd0, valid_b}, 32'd0);
        check("reset_addr_a", {26'd0, rom_addr_a}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Default position: white-on-black at (0,0), no Frame_Sig yet
        probe(0, 5, 3'b111, 5);
        probe(63, 5, 3'b111, 5);
        probe(64, 5, 3'b000, 5);
        probe(55, 5, 3'b111, 5);   // bitmap col 55 -> bit 8 (row bit 0)
        probe(54, 5, 3'b000, 5);   // bit 9 clear for row 5
        probe(1, 5, 3'b000, 5);

        // Offset and right-edge clipping, Bg = 001
        pos_x = 11'd780; pos_y = 11'd100; bg = 3'b001;
        frame_pulse();
        probe(780, 100, 3'b111, 0);
        probe(799, 100, 3'b111, 0);   // bitmap col 19
        probe(798, 100, 3'b001, 0);
        probe(779, 100, 3'b001, 0);
        probe(780, 163, 3'b111, 63);
        probe(780, 164, 3'b001, 0);

        // Off-screen position
        pos_x = 11'd2000; pos_y = 11'd0;
        frame_pulse();
        probe(0, 0, 3'b001, 0);
        probe(799, 0, 3'b001, 0);

        // 2x scaling at (10,10)
        scale = 1'b1; pos_x = 11'd10; pos_y = 11'd10; bg = 3'b000;
        frame_pulse();
        probe(10, 10, 3'b111, 0);
        probe(11, 10, 3'b111, 0);
        probe(12, 10, 3'b000, 0);
        probe(13, 12, 3'b000, 1);
        probe(137, 137, 3'b111, 63);
        probe(138, 137, 3'b000, 63);
        probe(10, 138, 3'b000, 0);
        probe(9, 10, 3'b000, 0);

        // Shadow timing: mid-frame changes wait for Frame_Sig
        scale = 1'b0; pos_x = 11'd0; pos_y = 11'd0; fg = 3'b111;
        frame_pulse();
        pos_x = 11'd100; fg = 3'b010;
        probe(0, 0, 3'b111, 0);
        frame_pulse();
        probe(100, 0, 3'b010, 0);
        probe(0, 0, 3'b000, 0);

        // Blink with BLINK_FRAMES = 3
        pos_x = 11'd0; fg = 3'b111; blink = 1'b1;
        frame_pulse();
        for (int k = 0; k < 9; k++) begin
            probe(0, 0, (k < 3 || k >= 6) ? 3'b111 : 3'b000, -1);
            frame_pulse();
        end
        probe(0, 0, 3'b000, -1);   // frame 9: hidden
        blink = 1'b0;
        frame_pulse();
        probe(0, 0, 3'b111, -1);

        // Exact latency: single Ready pulse on a foreground pixel
        @(negedge clk);
        ready = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        col = 11'd0; row = 11'd0; ready = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("lat_valid_a_c%0d", n), {31'd0, valid_a}, {31'd0, n == 2});
            check($sformatf("lat_red_a_c%0d", n), {31'd0, red_a}, {31'd0, n == 2});
            check($sformatf("lat_valid_b_c%0d", n), {31'd0, valid_b}, {31'd0, n == 4});
            check($sformatf("lat_red_b_c%0d", n), {31'd0, red_b}, {31'd0, n == 4});
            if (n == 1) begin
                @(negedge clk);
                ready = 1'b0;
                col   = 11'd64;
            end
        end

        // Mid-line reset: outputs drop at once, shadows return to defaults
        pos_x = 11'd100; fg = 3'b010;
        frame_pulse();
        probe(100, 0, 3'b010, 0);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_rgb_a", {29'd0, red_a, green_a, blue_a}, 32'd0);
        check("rst_rgb_b", {29'd0, red_b, green_b, blue_b}, 32'd0);
        check("rst_valid_a", {31'd0, valid_a}, 32'd0);
        check("rst_valid_b", {31'd0, valid_b}, 32'd0);
        @(negedge clk);
        col  = 11'd0;
        row  = 11'd0;
        rstn = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst_rgb_a_c%0d", n), {29'd0, red_a, green_a, blue_a},
                  (n >= 2) ? 32'd7 : 32'd0);
            check($sformatf("post_rst_rgb_b_c%0d", n), {29'd0, red_b, green_b, blue_b},
                  (n >= 4) ? 32'd7 : 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
